// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS IF stage: redirect encodings, reset/bubble
// constants and the fetch FSM state type.
package pipe_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/pipeif_fetch_if.sv
// Instruction-memory fetch bus: address/request from IF, word/ready from memory.
interface pipeif_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);

endinterface

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// The carry out is discarded, so the sum wraps modulo 2^32.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s
);

    logic [31:0] g;
    logic [31:0] p;
    logic [6:0]  bg;
    logic [6:0]  bp;
    logic [7:0]  cb;

    assign g = a & b;
    assign p = a ^ b;

    // Group carries are resolved here so no net feeds back into itself.
    always_comb begin
        cb[0] = ci;
        for (int k = 0; k < 7; k++) begin
            cb[k+1] = bg[k] | (bp[k] & cb[k]);
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_blk
        logic [3:0] gg;
        logic [3:0] pp;
        logic [3:0] cc;

        assign gg    = g[4*k +: 4];
        assign pp    = p[4*k +: 4];
        assign cc[0] = cb[k];
        assign cc[1] = gg[0] | (pp[0] & cc[0]);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & cc[0]);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & cc[0]);
        assign s[4*k +: 4] = pp ^ cc;

        if (k < 7) begin : g_grp
            assign bg[k] = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]);
            assign bp[k] = &pp;
        end
    end

endmodule

// File: rtl/mux4x32.sv
// Four-input 32-bit multiplexer.
module mux4x32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    always_comb begin
        unique case (s)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/pipeif_nextpc.sv
// Next-PC logic: redirect target mux, pc+4 adder and pending/redirect priority.
module pipeif_nextpc (
    input  logic [31:0] pc,
    input  logic [1:0]  pc_source,
    input  logic [31:0] branch_pc,
    input  logic [31:0] jump_pc,
    input  logic [31:0] reg_pc,
    input  logic        redir,
    input  logic        pend_valid,
    input  logic [31:0] pend_pc,
    output logic [31:0] target,
    output logic [31:0] pc_plus_4,
    output logic [31:0] next_pc
);

    cla32 u_add (
        .a  (pc),
        .b  (32'd4),
        .ci (1'b0),
        .s  (pc_plus_4)
    );

    mux4x32 u_target (
        .d0 (pc_plus_4),
        .d1 (branch_pc),
        .d2 (reg_pc),
        .d3 (jump_pc),
        .s  (pc_source),
        .y  (target)
    );

    // A redirect parked during a memory wait outranks anything ID says now.
    always_comb begin
        if (pend_valid) begin
            next_pc = pend_pc;
        end else if (redir) begin
            next_pc = target;
        end else begin
            next_pc = pc_plus_4;
        end
    end

endmodule

// File: rtl/pipeif_fetch.sv
// MIPS IF stage with IF/ID register: variable-latency fetch, stall hold,
// delay-slot-safe redirect that survives memory wait states.
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pc_source,
    input  logic [31:0]           branch_pc,
    input  logic [31:0]           jump_pc,
    input  logic [31:0]           reg_pc,
    input  logic                  nostall,
    pipeif_fetch_if.master        imem,
    output logic [31:0]           inst,
    output logic [31:0]           ID_pc_plus_4,
    output logic                  fetch_stall
);

    import pipe_pkg::*;

    fetch_state_e state;
    fetch_state_e state_next;

    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend_valid;
    logic [31:0] hold_inst;
    logic [31:0] word;
    logic [31:0] target;
    logic [31:0] pc_plus_4;
    logic [31:0] next_pc;
    logic        redir;
    logic        done;

    assign redir     = nostall && (pcsrc_e'(pc_source) != PCSRC_SEQ);
    assign imem.addr = pc;

    pipeif_nextpc u_nextpc (
        .pc         (pc),
        .pc_source  (pc_source),
        .branch_pc  (branch_pc),
        .jump_pc    (jump_pc),
        .reg_pc     (reg_pc),
        .redir      (redir),
        .pend_valid (pend_valid),
        .pend_pc    (pend_pc),
        .target     (target),
        .pc_plus_4  (pc_plus_4),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_next  = state;
        imem.req    = 1'b0;
        fetch_stall = 1'b0;
        done        = 1'b0;
        word        = imem.rdata;
        unique case (state)
            FETCH: begin
                imem.req = 1'b1;
                if (imem.ready) begin
                    done = 1'b1;
                    if (!nostall) state_next = HOLD;
                end else if (nostall) begin
                    fetch_stall = 1'b1;
                end
            end
            HOLD: begin
                done = 1'b1;
                word = hold_inst;
                if (nostall) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            inst         <= NOP_INST;
            ID_pc_plus_4 <= 32'h0;
            pend_valid   <= 1'b0;
        end else if (done && nostall) begin
            inst         <= word;
            ID_pc_plus_4 <= pc_plus_4;
            pc           <= next_pc;
            pend_valid   <= 1'b0;
        end else if (fetch_stall) begin
            // The word in flight is the delay slot; the redirect waits for it.
            inst <= NOP_INST;
            if (redir) pend_valid <= 1'b1;
        end
    end

    // NOTE: pure data registers carry no reset; their valid flags/state guard every use.
    always_ff @(posedge clk) begin
        if (fetch_stall && redir && !pend_valid) begin
            pend_pc <= target;
        end
        if (state == FETCH && imem.ready && !nostall) begin
            hold_inst <= imem.rdata;
        end
    end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Scenario bench for pipeif_fetch: expected IF/ID words are queued as fetches
// are driven and popped whenever ID consumes a non-bubble instruction.
module tb_pipeif_fetch;

    import pipe_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_source;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] reg_pc;
    logic        nostall;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] id_pc4;
    logic        fetch_stall;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'h8C, a[23:0]};
    endfunction

    pipeif_fetch_if bus ();

    assign bus.ready = ready;
    assign bus.rdata = ready ? mem_word(bus.addr) : 32'hDEAD_BEEF;

    pipeif_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_source    (pc_source),
        .branch_pc    (branch_pc),
        .jump_pc      (jump_pc),
        .reg_pc       (reg_pc),
        .nostall      (nostall),
        .imem         (bus),
        .inst         (inst),
        .ID_pc_plus_4 (id_pc4),
        .fetch_stall  (fetch_stall)
    );

    always #5 clk = ~clk;

    // Scoreboard: ID consumes IF/ID on every cycle with nostall=1.
    always @(negedge clk) begin
        if (!rst && nostall && inst !== NOP_INST) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: inst=%h pc4=%h delivered with no expected entry", inst, id_pc4);
            end else begin
                mon_e = q.pop_front();
                if (inst !== mon_e.inst || id_pc4 !== mon_e.pc4) begin
                    bad++;
                    $display("FAIL sb_word: inst=%h pc4=%h, expected inst=%h pc4=%h",
                             inst, id_pc4, mon_e.inst, mon_e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; ready = 1'b1; nostall = 1'b1; pc_source = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    // One cycle that lets ID consume the last delivered word while IF idles.
    task automatic drain();
        pc_source = 2'd0; nostall = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; nostall = 1'b1; pc_source = 2'd0;
        branch_pc = 32'h0; jump_pc = 32'h0; reg_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.req !== 1'b1 || bus.addr !== RESET_PC) begin
            bad++;
            $display("FAIL reset_bus: req=%b addr=%h, expected req=1 addr=%h", bus.req, bus.addr, RESET_PC);
        end
        total++;
        if (inst !== NOP_INST || id_pc4 !== 32'h0) begin
            bad++;
            $display("FAIL reset_ifid: inst=%h pc4=%h, expected %h/0", inst, id_pc4, NOP_INST);
        end
        total++;
        if (fetch_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: fetch_stall=%b, expected 0", fetch_stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pc_source = 2'd0; nostall = 1'b1; ready = 1'b1;
            q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
            @(negedge clk);
            total++;
            if (bus.addr !== 32'(4 * i) || bus.req !== 1'b1 || fetch_stall !== 1'b0) begin
                bad++;
                $display("FAIL seq[%0d]: addr=%h req=%b stall=%b, expected addr=%h req=1 stall=0",
                         i, bus.addr, bus.req, fetch_stall, 32'(4 * i));
            end
            @(posedge clk); #1;
        end
        drain();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL seq_left: %0d words undelivered, expected 0", q.size()); end
    endtask

    task automatic test_branch();
        logic [31:0] ea [8];
        logic [1:0]  src [8];
        ea  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h44};
        src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
        do_reset();
        branch_pc = 32'h40; jump_pc = 32'hBAD0_0000; reg_pc = 32'hBAD1_0000;
        for (int i = 0; i < 8; i++) begin
            pc_source = src[i]; nostall = 1'b1; ready = 1'b1;
            q.push_back({mem_word(ea[i]), ea[i] + 32'd4});
            @(negedge clk);
            total++;
            if (bus.addr !== ea[i] || fetch_stall !== 1'b0) begin
                bad++;
                $display("FAIL branch[%0d]: addr=%h stall=%b, expected addr=%h stall=0",
                         i, bus.addr, fetch_stall, ea[i]);
            end
            @(posedge clk); #1;
        end
        drain();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL branch_left: %0d words undelivered, expected 0", q.size()); end
    endtask

    task automatic test_wait_redirect();
        logic [31:0] ea [11];
        logic [1:0]  src [11];
        logic        rdy [11];
        ea  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h14, 32'h14, 32'h14, 32'h40, 32'h44};
        src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        branch_pc = 32'h40; jump_pc = 32'hBAD0_0000; reg_pc = 32'hBAD1_0000;
        for (int i = 0; i < 11; i++) begin
            pc_source = src[i]; nostall = 1'b1; ready = rdy[i];
            if (rdy[i]) q.push_back({mem_word(ea[i]), ea[i] + 32'd4});
            @(negedge clk);
            total++;
            if (bus.addr !== ea[i] || bus.req !== 1'b1 || fetch_stall !== !rdy[i]) begin
                bad++;
                $display("FAIL wait[%0d]: addr=%h req=%b stall=%b, expected addr=%h req=1 stall=%b",
                         i, bus.addr, bus.req, fetch_stall, ea[i], !rdy[i]);
            end
            if (i >= 6 && i <= 8) begin
                total++;
                if (inst !== NOP_INST) begin
                    bad++;
                    $display("FAIL wait_bubble[%0d]: inst=%h, expected %h", i, inst, NOP_INST);
                end
            end
            @(posedge clk); #1;
        end
        drain();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL wait_left: %0d words undelivered, expected 0", q.size()); end
    endtask

    task automatic test_hold();
        logic [31:0] ea [7];
        logic        ns [7];
        logic        rdy [7];
        logic        er [7];
        ea  = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10};
        ns  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        er  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pc_source = 2'd0; nostall = ns[i]; ready = rdy[i];
            if (er[i]) q.push_back({mem_word(ea[i]), ea[i] + 32'd4});
            @(negedge clk);
            total++;
            if (bus.addr !== ea[i] || bus.req !== er[i] || fetch_stall !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: addr=%h req=%b stall=%b, expected addr=%h req=%b stall=0",
                         i, bus.addr, bus.req, fetch_stall, ea[i], er[i]);
            end
            if (i == 3) begin
                total++;
                if (inst !== mem_word(32'h4)) begin
                    bad++;
                    $display("FAIL hold_ifid: inst=%h, expected %h", inst, mem_word(32'h4));
                end
            end
            @(posedge clk); #1;
        end
        drain();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL hold_left: %0d words undelivered, expected 0", q.size()); end
    endtask

    task automatic test_jumps();
        logic [31:0] ea [11];
        logic [1:0]  src [11];
        logic [31:0] jt [11];
        ea  = '{32'h0, 32'h4, 32'h8, 32'h1230, 32'h1234, 32'h1238, 32'h0040_0000,
                32'h0040_0004, 32'h0040_0008, 32'hFFFF_FFFC, 32'h0};
        src = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
        jt  = '{32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000,
                32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        do_reset();
        branch_pc = 32'h0000_BAD0; reg_pc = 32'h0000_1230;
        for (int i = 0; i < 11; i++) begin
            pc_source = src[i]; jump_pc = jt[i]; nostall = 1'b1; ready = 1'b1;
            q.push_back({mem_word(ea[i]), ea[i] + 32'd4});
            @(negedge clk);
            total++;
            if (bus.addr !== ea[i] || bus.req !== 1'b1) begin
                bad++;
                $display("FAIL jump[%0d]: addr=%h req=%b, expected addr=%h req=1",
                         i, bus.addr, bus.req, ea[i]);
            end
            @(posedge clk); #1;
        end
        drain();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL jump_left: %0d words undelivered, expected 0", q.size()); end
    endtask

    task automatic test_reset_midwait();
        logic [31:0] ea [4];
        logic [1:0]  src [4];
        logic        rdy [4];
        ea  = '{32'h0, 32'h4, 32'h8, 32'h8};
        src = '{2'd0, 2'd0, 2'd1, 2'd0};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        branch_pc = 32'h80; jump_pc = 32'hBAD0_0000; reg_pc = 32'hBAD1_0000;
        for (int i = 0; i < 4; i++) begin
            pc_source = src[i]; nostall = 1'b1; ready = rdy[i];
            if (rdy[i]) q.push_back({mem_word(ea[i]), ea[i] + 32'd4});
            @(negedge clk);
            total++;
            if (bus.addr !== ea[i] || fetch_stall !== !rdy[i]) begin
                bad++;
                $display("FAIL rstwait[%0d]: addr=%h stall=%b, expected addr=%h stall=%b",
                         i, bus.addr, fetch_stall, ea[i], !rdy[i]);
            end
            @(posedge clk); #1;
        end
        // Reset lands with a redirect pending and a late ready on the old request.
        rst = 1'b1; ready = 1'b1; pc_source = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_source = 2'd0; nostall = 1'b1; ready = 1'b1;
            q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
            @(negedge clk);
            total++;
            if (bus.addr !== RESET_PC + 32'(4 * i) || bus.req !== 1'b1) begin
                bad++;
                $display("FAIL rst_resume[%0d]: addr=%h req=%b, expected addr=%h req=1",
                         i, bus.addr, bus.req, RESET_PC + 32'(4 * i));
            end
            if (i == 0) begin
                total++;
                if (inst !== NOP_INST || fetch_stall !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_ifid: inst=%h stall=%b, expected %h/0", inst, fetch_stall, NOP_INST);
                end
            end
            @(posedge clk); #1;
        end
        drain();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rst_left: %0d words undelivered, expected 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait_redirect();
        test_hold();
        test_jumps();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
